alu_issuer: RTL and testbench

ALU_ISSUER -- requirements
Module: alu_issuer

---
 rtl/alu_issuer_pkg.sv | 72 +++++++
 rtl/alu_issue_decode.sv | 72 +++++++
 rtl/alu_issuer.sv | 157 +++++++++++++++
 tb/tb_alu_issuer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issuer_pkg.sv
// ============================================================================
// Module : alu_issuer_pkg
// Brief  : ALU op codes, MIPS opcode/funct values and issuer FSM/select types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_issuer_pkg;

    localparam logic [3:0] c_aluc_addu = 4'b0000;
    localparam logic [3:0] c_aluc_subu = 4'b0001;
    localparam logic [3:0] c_aluc_add  = 4'b0010;
    localparam logic [3:0] c_aluc_sub  = 4'b0011;
    localparam logic [3:0] c_aluc_and  = 4'b0100;
    localparam logic [3:0] c_aluc_or   = 4'b0101;
    localparam logic [3:0] c_aluc_xor  = 4'b0110;
    localparam logic [3:0] c_aluc_nor  = 4'b0111;
    localparam logic [3:0] c_aluc_lui  = 4'b1000;
    localparam logic [3:0] c_aluc_sltu = 4'b1010;
    localparam logic [3:0] c_aluc_slt  = 4'b1011;
    localparam logic [3:0] c_aluc_sra  = 4'b1100;
    localparam logic [3:0] c_aluc_srl  = 4'b1101;
    localparam logic [3:0] c_aluc_sll  = 4'b1110;

    localparam logic [5:0] c_op_rtype  = 6'b000000;
    localparam logic [5:0] c_op_addi   = 6'b001000;
    localparam logic [5:0] c_op_addiu  = 6'b001001;
    localparam logic [5:0] c_op_slti   = 6'b001010;
    localparam logic [5:0] c_op_sltiu  = 6'b001011;
    localparam logic [5:0] c_op_andi   = 6'b001100;
    localparam logic [5:0] c_op_ori    = 6'b001101;
    localparam logic [5:0] c_op_xori   = 6'b001110;
    localparam logic [5:0] c_op_lui    = 6'b001111;

    localparam logic [5:0] c_fn_sll    = 6'b000000;
    localparam logic [5:0] c_fn_srl    = 6'b000010;
    localparam logic [5:0] c_fn_sra    = 6'b000011;
    localparam logic [5:0] c_fn_sllv   = 6'b000100;
    localparam logic [5:0] c_fn_srlv   = 6'b000110;
    localparam logic [5:0] c_fn_srav   = 6'b000111;
    localparam logic [5:0] c_fn_add    = 6'b100000;
    localparam logic [5:0] c_fn_addu   = 6'b100001;
    localparam logic [5:0] c_fn_sub    = 6'b100010;
    localparam logic [5:0] c_fn_subu   = 6'b100011;
    localparam logic [5:0] c_fn_and    = 6'b100100;
    localparam logic [5:0] c_fn_or     = 6'b100101;
    localparam logic [5:0] c_fn_xor    = 6'b100110;
    localparam logic [5:0] c_fn_nor    = 6'b100111;
    localparam logic [5:0] c_fn_slt    = 6'b101010;
    localparam logic [5:0] c_fn_sltu   = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        A_RS    = 2'd0,
        A_SHAMT = 2'd1,
        A_ZERO  = 2'd2
    } a_sel_t;

    typedef enum logic [1:0] {
        B_RT       = 2'd0,
        B_IMM_SEXT = 2'd1,
        B_IMM_ZEXT = 2'd2
    } b_sel_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_decode.sv
// ============================================================================
// Module : alu_issue_decode
// Brief  : Combinational MIPS decode to ALU op, operand selects and dest reg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_decode
    import alu_issuer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  aluc,
    output a_sel_t      a_sel,
    output b_sel_t      b_sel,
    output logic [4:0]  dest,
    output logic        legal,
    output logic        trap_eligible
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_rs;

    assign w_op        = instr[31:26];
    assign w_funct     = instr[5:0];
    assign w_unused_rs = ^instr[25:21];

    always_comb begin
        aluc          = c_aluc_addu;
        a_sel         = A_RS;
        b_sel         = B_RT;
        dest          = instr[15:11];
        legal         = 1'b1;
        trap_eligible = 1'b0;
        case (w_op)
            c_op_rtype: begin
                case (w_funct)
                    c_fn_add:  begin aluc = c_aluc_add; trap_eligible = 1'b1; end
                    c_fn_addu: aluc = c_aluc_addu;
                    c_fn_sub:  begin aluc = c_aluc_sub; trap_eligible = 1'b1; end
                    c_fn_subu: aluc = c_aluc_subu;
                    c_fn_and:  aluc = c_aluc_and;
                    c_fn_or:   aluc = c_aluc_or;
                    c_fn_xor:  aluc = c_aluc_xor;
                    c_fn_nor:  aluc = c_aluc_nor;
                    c_fn_slt:  aluc = c_aluc_slt;
                    c_fn_sltu: aluc = c_aluc_sltu;
                    c_fn_sll:  begin aluc = c_aluc_sll; a_sel = A_SHAMT; end
                    c_fn_srl:  begin aluc = c_aluc_srl; a_sel = A_SHAMT; end
                    c_fn_sra:  begin aluc = c_aluc_sra; a_sel = A_SHAMT; end
                    c_fn_sllv: aluc = c_aluc_sll;
                    c_fn_srlv: aluc = c_aluc_srl;
                    c_fn_srav: aluc = c_aluc_sra;
                    default:   legal = 1'b0;
                endcase
            end
            // I-type: destination moves to the rt field
            c_op_addi:  begin aluc = c_aluc_add;  b_sel = B_IMM_SEXT; dest = instr[20:16]; trap_eligible = 1'b1; end
            c_op_addiu: begin aluc = c_aluc_addu; b_sel = B_IMM_SEXT; dest = instr[20:16]; end
            c_op_slti:  begin aluc = c_aluc_slt;  b_sel = B_IMM_SEXT; dest = instr[20:16]; end
            c_op_sltiu: begin aluc = c_aluc_sltu; b_sel = B_IMM_SEXT; dest = instr[20:16]; end
            c_op_andi:  begin aluc = c_aluc_and;  b_sel = B_IMM_ZEXT; dest = instr[20:16]; end
            c_op_ori:   begin aluc = c_aluc_or;   b_sel = B_IMM_ZEXT; dest = instr[20:16]; end
            c_op_xori:  begin aluc = c_aluc_xor;  b_sel = B_IMM_ZEXT; dest = instr[20:16]; end
            c_op_lui:   begin aluc = c_aluc_lui;  a_sel = A_ZERO; b_sel = B_IMM_ZEXT; dest = instr[20:16]; end
            default:    legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issuer.sv
// ============================================================================
// Module : alu_issuer
// Brief  : Single-in-flight MIPS ALU instruction issuer with result capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issuer
    import alu_issuer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        out_wr_en,
    output logic [4:0]  out_wr_addr,
    output logic        out_illegal,
    output logic        out_ovf_trap
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic [31:0] w_dec_instr;
    logic [3:0]  w_aluc;
    a_sel_t      w_a_sel;
    b_sel_t      w_b_sel;
    logic [4:0]  w_dest;
    logic        w_legal;
    logic        w_trap_elig;
    logic        w_trap;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;

    // Decode the live instruction while idle (to spot illegal ones at accept),
    // and the registered one afterwards.
    assign w_dec_instr = (r_state == ST_IDLE) ? in_instr : r_instr;

    alu_issue_decode u_decode (
        .instr         (w_dec_instr),
        .aluc          (w_aluc),
        .a_sel         (w_a_sel),
        .b_sel         (w_b_sel),
        .dest          (w_dest),
        .legal         (w_legal),
        .trap_eligible (w_trap_elig)
    );

    always_comb begin
        case (w_a_sel)
            A_SHAMT: w_op_a = {27'b0, r_instr[10:6]};
            A_ZERO:  w_op_a = 32'b0;
            default: w_op_a = r_rs;
        endcase
        case (w_b_sel)
            B_IMM_SEXT: w_op_b = {{16{r_instr[15]}}, r_instr[15:0]};
            B_IMM_ZEXT: w_op_b = {16'b0, r_instr[15:0]};
            default:    w_op_b = r_rt;
        endcase
    end

    assign w_trap = w_trap_elig & alu_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        alu_a        = 32'b0;
        alu_b        = 32'b0;
        alu_aluc     = 4'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = w_legal ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                alu_a        = w_op_a;
                alu_b        = w_op_b;
                alu_aluc     = w_aluc;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr      <= 32'b0;
            r_rs         <= 32'b0;
            r_rt         <= 32'b0;
            out_result   <= 32'b0;
            out_flags    <= 4'b0;
            out_wr_en    <= 1'b0;
            out_wr_addr  <= 5'b0;
            out_illegal  <= 1'b0;
            out_ovf_trap <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_instr <= in_instr;
                r_rs    <= in_rs;
                r_rt    <= in_rt;
                if (!w_legal) begin
                    out_result   <= 32'b0;
                    out_flags    <= 4'b0;
                    out_wr_en    <= 1'b0;
                    out_wr_addr  <= 5'b0;
                    out_illegal  <= 1'b1;
                    out_ovf_trap <= 1'b0;
                end
            end
            if (r_state == ST_ISSUE) begin
                out_result   <= alu_r;
                out_flags    <= {alu_zero, alu_carry, alu_negative, alu_overflow};
                out_wr_en    <= (w_dest != 5'd0) && !w_trap;
                out_wr_addr  <= w_dest;
                out_illegal  <= 1'b0;
                out_ovf_trap <= w_trap;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issuer.sv
// ============================================================================
// Module : tb_alu_issuer
// Brief  : Randomized self-checking bench for alu_issuer with a paired ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issuer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        out_wr_en;
    logic [4:0]  out_wr_addr;
    logic        out_illegal;
    logic        out_ovf_trap;

    int n_chk = 0;
    int n_err = 0;

    alu_issuer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_aluc     (alu_aluc),
        .alu_r        (alu_r),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr),
        .out_illegal  (out_illegal),
        .out_ovf_trap (out_ovf_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team ALU: carry is carry-out for add, borrow for subtract.
    logic [32:0] alu_s;
    always_comb begin
        alu_s        = 33'b0;
        alu_r        = 32'b0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_aluc)
            4'b0000, 4'b0010: begin
                alu_s     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r     = alu_s[31:0];
                alu_carry = alu_s[32];
                if (alu_aluc == 4'b0010)
                    alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0001, 4'b0011: begin
                alu_r     = alu_a - alu_b;
                alu_carry = alu_a < alu_b;
                if (alu_aluc == 4'b0011)
                    alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0100: alu_r = alu_a & alu_b;
            4'b0101: alu_r = alu_a | alu_b;
            4'b0110: alu_r = alu_a ^ alu_b;
            4'b0111: alu_r = ~(alu_a | alu_b);
            4'b1000, 4'b1001: alu_r = {alu_b[15:0], 16'h0};
            4'b1011: alu_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b1010: alu_r = {31'b0, alu_a < alu_b};
            4'b1100: alu_r = $signed(alu_b) >>> alu_a[4:0];
            4'b1101: alu_r = alu_b >> alu_a[4:0];
            4'b1110, 4'b1111: alu_r = alu_b << alu_a[4:0];
            default: alu_r = 32'b0;
        endcase
    end
    assign alu_zero     = (alu_r == 32'b0);
    assign alu_negative = alu_r[31];

    typedef struct packed {
        logic        legal;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic [3:0]  flags;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic        trap;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic add_ovf(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic sub_ovf(input logic [31:0] x, input logic [31:0] y);
        longint s;
        s = longint'($signed(x)) - longint'($signed(y));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic add_carry(input logic [31:0] x, input logic [31:0] y);
        longint unsigned u;
        u = longint'({32'b0, x}) + longint'({32'b0, y});
        return u > 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Instruction-level semantics of every supported MIPS op.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] sh;
        logic [31:0] sx;
        logic [31:0] zx;
        logic       carry;
        logic       ovf;
        logic       elig;
        op = instr[31:26];
        fn = instr[5:0];
        sh = instr[10:6];
        sx = {{16{instr[15]}}, instr[15:0]};
        zx = {16'h0, instr[15:0]};
        e = '0;
        e.legal = 1'b1;
        carry = 1'b0;
        ovf = 1'b0;
        elig = 1'b0;
        if (op == 6'b000000) begin
            e.wr_addr = instr[15:11];
            e.a = rs;
            e.b = rt;
            case (fn)
                6'b100000: begin e.aluc = 4'b0010; e.result = rs + rt; carry = add_carry(rs, rt); ovf = add_ovf(rs, rt); elig = 1'b1; end
                6'b100001: begin e.aluc = 4'b0000; e.result = rs + rt; carry = add_carry(rs, rt); end
                6'b100010: begin e.aluc = 4'b0011; e.result = rs - rt; carry = rs < rt; ovf = sub_ovf(rs, rt); elig = 1'b1; end
                6'b100011: begin e.aluc = 4'b0001; e.result = rs - rt; carry = rs < rt; end
                6'b100100: begin e.aluc = 4'b0100; e.result = rs & rt; end
                6'b100101: begin e.aluc = 4'b0101; e.result = rs | rt; end
                6'b100110: begin e.aluc = 4'b0110; e.result = rs ^ rt; end
                6'b100111: begin e.aluc = 4'b0111; e.result = ~(rs | rt); end
                6'b101010: begin e.aluc = 4'b1011; e.result = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
                6'b101011: begin e.aluc = 4'b1010; e.result = (rs < rt) ? 32'd1 : 32'd0; end
                6'b000000: begin e.aluc = 4'b1110; e.a = {27'b0, sh}; e.result = rt << sh; end
                6'b000010: begin e.aluc = 4'b1101; e.a = {27'b0, sh}; e.result = rt >> sh; end
                6'b000011: begin e.aluc = 4'b1100; e.a = {27'b0, sh}; e.result = $signed(rt) >>> sh; end
                6'b000100: begin e.aluc = 4'b1110; e.result = rt << rs[4:0]; end
                6'b000110: begin e.aluc = 4'b1101; e.result = rt >> rs[4:0]; end
                6'b000111: begin e.aluc = 4'b1100; e.result = $signed(rt) >>> rs[4:0]; end
                default:   e.legal = 1'b0;
            endcase
        end else begin
            e.wr_addr = instr[20:16];
            e.a = rs;
            case (op)
                6'b001000: begin e.aluc = 4'b0010; e.b = sx; e.result = rs + sx; carry = add_carry(rs, sx); ovf = add_ovf(rs, sx); elig = 1'b1; end
                6'b001001: begin e.aluc = 4'b0000; e.b = sx; e.result = rs + sx; carry = add_carry(rs, sx); end
                6'b001010: begin e.aluc = 4'b1011; e.b = sx; e.result = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0; end
                6'b001011: begin e.aluc = 4'b1010; e.b = sx; e.result = (rs < sx) ? 32'd1 : 32'd0; end
                6'b001100: begin e.aluc = 4'b0100; e.b = zx; e.result = rs & zx; end
                6'b001101: begin e.aluc = 4'b0101; e.b = zx; e.result = rs | zx; end
                6'b001110: begin e.aluc = 4'b0110; e.b = zx; e.result = rs ^ zx; end
                6'b001111: begin e.aluc = 4'b1000; e.a = 32'b0; e.b = zx; e.result = {instr[15:0], 16'h0}; end
                default:   e.legal = 1'b0;
            endcase
        end
        if (!e.legal) begin
            e = '0;
            return e;
        end
        e.flags = {e.result == 32'b0, carry, e.result[31], ovf};
        e.trap = elig & ovf;
        e.wr_en = (e.wr_addr != 5'd0) && !e.trap;
        return e;
    endfunction

    // Drives one instruction from a negedge and checks it through to IDLE again.
    task automatic do_instr(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt, input int hold);
        exp_t e;
        e = model(instr, rs, rt);
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_instr = instr;
        in_rs    = rs;
        in_rt    = rt;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = $urandom;
        in_rs    = $urandom;
        in_rt    = $urandom;
        if (e.legal) begin
            check_eq("issue_out_valid", 32'(out_valid), 32'd0);
            check_eq("issue_in_ready", 32'(in_ready), 32'd0);
            check_eq("issue_aluc", 32'(alu_aluc), 32'(e.aluc));
            check_eq("issue_alu_a", alu_a, e.a);
            check_eq("issue_alu_b", alu_b, e.b);
            @(negedge clk);
        end
        for (int i = 0; i <= hold; i++) begin
            check_eq("done_out_valid", 32'(out_valid), 32'd1);
            check_eq("done_in_ready", 32'(in_ready), 32'd0);
            check_eq("done_alu_drive", alu_a | alu_b | 32'(alu_aluc), 32'd0);
            check_eq("out_result", out_result, e.result);
            check_eq("out_flags", 32'(out_flags), 32'(e.flags));
            check_eq("out_wr_en", 32'(out_wr_en), 32'(e.wr_en));
            check_eq("out_wr_addr", 32'(out_wr_addr), 32'(e.wr_addr));
            check_eq("out_illegal", 32'(out_illegal), 32'(!e.legal));
            check_eq("out_ovf_trap", 32'(out_ovf_trap), 32'(e.trap));
            if (i == hold) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("after_out_valid", 32'(out_valid), 32'd0);
        check_eq("after_in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        int          sel;
        logic [5:0]  fn;
        logic [4:0]  rd;
        logic [31:0] w;
        sel = $urandom_range(0, 26);
        w   = $urandom;
        rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        if (sel < 16) begin
            case (sel)
                0: fn = 6'b100000;  1: fn = 6'b100001;  2: fn = 6'b100010;  3: fn = 6'b100011;
                4: fn = 6'b100100;  5: fn = 6'b100101;  6: fn = 6'b100110;  7: fn = 6'b100111;
                8: fn = 6'b101010;  9: fn = 6'b101011; 10: fn = 6'b000000; 11: fn = 6'b000010;
                12: fn = 6'b000011; 13: fn = 6'b000100; 14: fn = 6'b000110; default: fn = 6'b000111;
            endcase
            return {6'b000000, w[25:16], rd, w[10:6], fn};
        end else if (sel < 24) begin
            return {6'(sel - 16 + 8), w[25:21], rd, w[15:0]};
        end else if (sel == 24) begin
            return {6'b000000, w[25:6], 6'b001000};
        end else if (sel == 25) begin
            return {6'b100011, w[25:0]};
        end
        return {6'b000010, w[25:0]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'b0;
        in_rs     = 32'b0;
        in_rt     = 32'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_out_misc", {out_flags, out_wr_en, out_wr_addr, out_illegal, out_ovf_trap}, 32'd0);
        check_eq("rst_alu_drive", alu_a | alu_b | 32'(alu_aluc), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);

        // add $3,$1,$2 ; add overflow ; sra $4,$5,4 ; lui $6,0x1234 ; j held 5 cycles
        do_instr({6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'd5, 32'd7, 0);
        check_eq("add_const", out_result, 32'd12);
        do_instr({6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000}, 32'h7FFF_FFFF, 32'd1, 1);
        check_eq("ovf_const", out_result, 32'h8000_0000);
        do_instr({6'b0, 5'd0, 5'd5, 5'd4, 5'd4, 6'b000011}, 32'h1234_5678, 32'hF000_0000, 0);
        check_eq("sra_const", out_result, 32'hFF00_0000);
        do_instr({6'b001111, 5'd0, 5'd6, 16'h1234}, 32'h0, 32'h0, 0);
        check_eq("lui_const", out_result, 32'h1234_0000);
        do_instr({6'b000010, 26'h0123456}, 32'hDEAD_BEEF, 32'h1, 5);

        for (int n = 0; n < 80; n++) begin
            do_instr(rand_instr(), rand_val(), rand_val(), $urandom_range(0, 2));
        end

        // Reset asserted while the instruction is in ISSUE.
        in_valid = 1'b1;
        in_instr = {6'b0, 5'd1, 5'd2, 5'd9, 5'd0, 6'b100001};
        in_rs    = 32'd100;
        in_rt    = 32'd23;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("pre_rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_alu_drive", alu_a | alu_b | 32'(alu_aluc), 32'd0);
        check_eq("mid_rst_out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        do_instr({6'b001101, 5'd0, 5'd7, 16'hFFFF}, 32'h0, 32'h0, 0);
        check_eq("ori_const", out_result, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
